// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: ALU control codes and FSM state encoding.
package div_unit_pkg;

    localparam logic [3:0] DIV_CONTROL  = 4'b1010;
    localparam logic [3:0] DIVU_CONTROL = 4'b1011;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/div_unit_iter_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract the divisor.
module div_iter_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_o
);

    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    assign w_shifted = {rem_i, bit_i};
    assign w_diff    = w_shifted - {1'b0, divisor_i};

    // A set top bit means the trial went negative; the shifted value then fits in WIDTH bits.
    assign q_o   = ~w_diff[WIDTH];
    assign rem_o = w_diff[WIDTH] ? w_shifted[WIDTH-1:0] : w_diff[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in EX; stalls EX until the result is ready.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic             hold_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             stall_o,
    output logic             ready_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;
    logic             r_neg_q;
    logic             r_neg_r;
    logic [CntW-1:0]  r_cnt;

    logic [WIDTH-1:0] w_rem_next;
    logic [WIDTH-1:0] w_quot_next;
    logic [WIDTH-1:0] w_dvd_abs;
    logic [WIDTH-1:0] w_dvs_abs;
    logic             w_qbit;
    logic             w_accept;
    logic             w_last;

    assign w_accept    = start_i & ~annul_i;
    assign w_last      = (r_cnt == CntW'(WIDTH - 1));
    assign w_dvd_abs   = (signed_i & dividend_i[WIDTH-1]) ? -dividend_i : dividend_i;
    assign w_dvs_abs   = (signed_i & divisor_i[WIDTH-1]) ? -divisor_i : divisor_i;
    assign w_quot_next = {r_dvd[WIDTH-2:0], w_qbit};

    // r_dvd shifts out dividend bits at the top while quotient bits fill in at the bottom.
    div_iter_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .rem_i    (r_rem),
        .bit_i    (r_dvd[WIDTH-1]),
        .divisor_i(r_dvs),
        .rem_o    (w_rem_next),
        .q_o      (w_qbit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (annul_i) begin
            w_state_next = StIdle;
        end else begin
            unique case (r_state)
                StIdle:  if (start_i) w_state_next = (divisor_i == '0) ? StDone : StBusy;
                StBusy:  if (w_last) w_state_next = StDone;
                StDone:  if (!hold_i) w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    always_comb begin
        stall_o = 1'b0;
        ready_o = 1'b0;
        case (r_state)
            StIdle:  stall_o = w_accept;
            StBusy:  stall_o = ~annul_i;
            StDone:  ready_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_remo  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        if (divisor_i != '0) begin
                            r_dvd   <= w_dvd_abs;
                            r_dvs   <= w_dvs_abs;
                            r_rem   <= '0;
                            r_cnt   <= '0;
                            r_neg_q <= signed_i & (dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1]);
                            r_neg_r <= signed_i & dividend_i[WIDTH-1];
                        end else begin
                            r_quot <= '1;
                            r_remo <= dividend_i;
                        end
                    end
                end
                StBusy: begin
                    if (!annul_i) begin
                        r_rem <= w_rem_next;
                        r_dvd <= w_quot_next;
                        r_cnt <= r_cnt + 1'b1;
                        if (w_last) begin
                            r_quot <= r_neg_q ? -w_quot_next : w_quot_next;
                            r_remo <= r_neg_r ? -w_rem_next : w_rem_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient_o  = r_quot;
    assign remainder_o = r_remo;

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Iterative radix-2 restoring divider for the EX stage. Executes MIPS DIV/DIVU: LO = quotient, HI = remainder.
Runs beside the ALU's pipelined multiplier and uses the same stall contract. EX is held via stall_o until the result is valid, and an EX flush annuls any operation in progress.

Parameters:
WIDTH, 32, operand/result width in bits (counter width = clog2(WIDTH)+1)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous active-high reset
start_i  in  1  EX holds a DIV/DIVU; held high by the pipeline until it advances
signed_i  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i
annul_i  in  1  EX flush / exception in MEM; aborts the operation
hold_i  in  1  downstream stall; keeps DONE state while high
dividend_i  in  WIDTH  rs operand; sampled at start
divisor_i  in  WIDTH  rt operand; sampled at start
stall_o  out  1  stall EX/earlier stages; combinational
ready_o  out  1  quotient_o/remainder_o valid this cycle
quotient_o  out  WIDTH  to LO write path
remainder_o  out  WIDTH  to HI write path

Behaviour:
- Reset: state = IDLE; quotient_o, remainder_o, internal regs and counter = 0; ready_o = 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - start_i & ~annul_i & divisor_i != 0: latch |dividend| and |divisor| (absolute values only if signed_i), plus the result sign flags; clear the partial remainder; counter = 0; go to BUSY.
  - start_i & ~annul_i & divisor_i == 0: quotient = all-ones, remainder = dividend_i unmodified (fixed value; MIPS leaves it undefined); go to DONE next cycle.
- BUSY, one quotient bit per cycle, MSB first:
  - Shift {rem, dividend}; trial subtract the divisor. If the result is non-negative, keep it and set quotient bit = 1; otherwise restore and set bit = 0.
  - After WIDTH iterations (counter == WIDTH-1), apply signs: negate quotient if dividend and divisor signs differ; remainder takes the dividend's sign; both apply only when signed_i was latched.
  - Load the output registers and go to DONE.
- DONE:
  - ready_o = 1 and results are stable.
  - hold_i = 1: stay in DONE.
  - Otherwise: go to IDLE. The next instruction's start_i in IDLE begins a new operation; there is no back-to-back start in the DONE cycle.
- stall_o = (IDLE & start_i & ~annul_i) | BUSY. It is 0 in DONE, so EX can advance that cycle.
- Latency for a nonzero divisor: start seen at cycle T, BUSY cycles T+1..T+WIDTH, ready_o at T+WIDTH+1. Divide by zero: ready_o at T+1.
- annul_i in any state: IDLE next cycle, ready_o = 0 next cycle, stall_o = 0 in the same cycle (gated). Output registers keep their previous values. annul_i has priority over start_i and hold_i.
- rst_i has priority over everything, including mid-BUSY; it behaves as the reset values.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0 (natural modulo-2^WIDTH result, no trap).
- quotient_o/remainder_o change only on the BUSY->DONE or IDLE->DONE transition.

Decomposition:
- Shared defines header: DIV_CONTROL and DIVU_CONTROL alucontrol codes, and the state encoding constants (IDLE/BUSY/DONE).
- One sub-module is natural: div_iter_step, a combinational single-iteration shift/trial-subtract (rem, dividend bit, divisor -> next rem, quotient bit). It is unit-testable on its own.
- Sign fix-up stays inline.

Test Plan:
- DIVU 100 / 7, start held, hold_i = 0 -> stall_o high for 33 cycles (T..T+32); ready_o at T+33 with quotient 14 (0xE), remainder 2; back in IDLE at T+34.
- DIV -7 / 2 (0xFFFFFFF9 / 2) -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1); DIV 7 / -2 -> quotient 0xFFFFFFFD, remainder 1.
- DIV 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0, ready_o at T+33, no other flags.
- DIVU 0x12345678 / 0 -> ready_o at T+1, quotient 0xFFFFFFFF, remainder 0x12345678, stall_o high only in cycle T.
- Start DIVU 50 / 5, assert annul_i at T+10 -> IDLE at T+11, no ready_o, outputs keep the previous result. A following DIVU 9 / 4 returns 2 and 1 after the full 33 cycles.
- ready_o with hold_i high for 3 cycles -> DONE and outputs held 4 cycles total, stall_o = 0 throughout. Reset asserted mid-BUSY -> IDLE, all outputs 0 next cycle.
